// File: rtl/tx_serial_pkg.sv
// Shared definitions for the parametrised serial transmitter.
// Holds the parity-mode codes, the FSM state encoding and a constant-time
// ceil(log2) helper used to size counters from parameters.
package tx_serial_pkg;

    // Parity mode codes accepted by the PARITY parameter
    localparam int PARIDADE_NENHUMA = 0;
    localparam int PARIDADE_PAR     = 1;
    localparam int PARIDADE_IMPAR   = 2;

    // FSM state encoding
    localparam logic [2:0] COD_IDLE   = 3'd0;
    localparam logic [2:0] COD_START  = 3'd1;
    localparam logic [2:0] COD_DATA   = 3'd2;
    localparam logic [2:0] COD_PARITY = 3'd3;
    localparam logic [2:0] COD_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = COD_IDLE,
        ST_START  = COD_START,
        ST_DATA   = COD_DATA,
        ST_PARITY = COD_PARITY,
        ST_STOP   = COD_STOP
    } estado_t;

    // Smallest width able to hold values 0..valor-1
    function automatic int clog2_f(input int valor);
        int res;
        res = 0;
        for (int n = 0; n < 31; n++) begin
            if ((64'd1 << n) < 64'(valor)) begin
                res = n + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tx_serial_tick_gen.sv
// Baud-tick generator: modulo-BAUD_DIV counter.
// Ports:
//   clock    - system clock (rising edge)
//   reset    - asynchronous active-low reset
//   clear    - synchronous clear back to zero (wins over enable)
//   enable   - count while high
//   tick     - high during the terminal-count cycle (last cycle of a bit)
//   pre_tick - high one cycle before the terminal count, lets the parent
//              register an output that must coincide with tick
module tx_serial_tick_gen
    import tx_serial_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick,
    output logic pre_tick
);

    localparam int CNT_W = clog2_f(BAUD_DIV);
    localparam logic [CNT_W-1:0] TERMINAL     = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] PRE_TERMINAL = CNT_W'(BAUD_DIV - 2);

    logic [CNT_W-1:0] count_r;

    // Cycle counter within the current bit period
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable) begin
            if (count_r == TERMINAL) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + CNT_W'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign tick     = enable && (count_r == TERMINAL);
    assign pre_tick = enable && (count_r == PRE_TERMINAL);

endmodule

// File: rtl/tx_serial_param.sv
// Parametrised asynchronous serial transmitter.
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1),
// each bit BAUD_DIV clock cycles long.
// Ports:
//   clock        - system clock (rising edge)
//   reset        - asynchronous active-low reset
//   tx_valid     - producer offers a character on dados
//   tx_ready     - registered, high only while idle
//   dados        - character, captured on acceptance only
//   saida_serial - registered serial line, idle high
//   ocupado      - registered, high while a frame is in progress
//   pronto       - registered one-cycle pulse in the last cycle of the final stop bit
module tx_serial_param
    import tx_serial_pkg::*;
#(
    parameter int DATA_BITS = 7,
    parameter int PARITY    = 1,
    parameter int STOP_BITS = 1,
    parameter int BAUD_DIV  = 434
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] dados,
    output logic                 saida_serial,
    output logic                 ocupado,
    output logic                 pronto
);

    generate
        if ((DATA_BITS < 5) || (DATA_BITS > 9) || (PARITY < 0) || (PARITY > 2) ||
            (STOP_BITS < 1) || (STOP_BITS > 2) || (BAUD_DIV < 2)) begin : g_param_invalido
            $error("tx_serial_param: illegal parameter combination");
        end
    endgenerate

    localparam int BIT_W = clog2_f(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] ULTIMO_DADO = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] ULTIMO_STOP = BIT_W'(STOP_BITS - 1);

    // Parity bit for the selected mode
    function automatic logic calc_paridade(input logic [DATA_BITS-1:0] d);
        logic p;
        p = ^d;
        if (PARITY == PARIDADE_IMPAR) begin
            return ~p;
        end else begin
            return p;
        end
    endfunction

    estado_t              estado_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 paridade_r;
    logic [BIT_W-1:0]     bit_cnt_r;
    logic                 saida_r;
    logic                 ready_r;
    logic                 ocupado_r;
    logic                 pronto_r;
    logic                 accept_s;
    logic                 tick_s;
    logic                 pre_tick_s;

    // ready_r is only high in IDLE, so acceptance can only happen there
    assign accept_s = tx_valid && ready_r;

    tx_serial_tick_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tick (
        .clock    (clock),
        .reset    (reset),
        .clear    (accept_s),
        .enable   (ocupado_r),
        .tick     (tick_s),
        .pre_tick (pre_tick_s)
    );

    // Transmit FSM with shift register, bit counter and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_r   <= ST_IDLE;
            shift_r    <= '0;
            paridade_r <= 1'b0;
            bit_cnt_r  <= '0;
            saida_r    <= 1'b1;
            ready_r    <= 1'b1;
            ocupado_r  <= 1'b0;
            pronto_r   <= 1'b0;
        end else begin
            pronto_r <= 1'b0;
            case (estado_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        estado_r   <= ST_START;
                        shift_r    <= dados;
                        paridade_r <= calc_paridade(dados);
                        bit_cnt_r  <= '0;
                        saida_r    <= 1'b0;
                        ready_r    <= 1'b0;
                        ocupado_r  <= 1'b1;
                    end else begin
                        saida_r   <= 1'b1;
                        ready_r   <= 1'b1;
                        ocupado_r <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        estado_r  <= ST_DATA;
                        saida_r   <= shift_r[0];
                        shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
                        bit_cnt_r <= '0;
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        if (bit_cnt_r == ULTIMO_DADO) begin
                            bit_cnt_r <= '0;
                            if (PARITY != PARIDADE_NENHUMA) begin
                                estado_r <= ST_PARITY;
                                saida_r  <= paridade_r;
                            end else begin
                                estado_r <= ST_STOP;
                                saida_r  <= 1'b1;
                            end
                        end else begin
                            saida_r   <= shift_r[0];
                            shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
                            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick_s) begin
                        estado_r  <= ST_STOP;
                        saida_r   <= 1'b1;
                        bit_cnt_r <= '0;
                    end
                end
                ST_STOP: begin
                    // Raised one cycle early so the pulse lands on the final stop cycle
                    pronto_r <= pre_tick_s && (bit_cnt_r == ULTIMO_STOP);
                    if (tick_s) begin
                        if (bit_cnt_r == ULTIMO_STOP) begin
                            estado_r  <= ST_IDLE;
                            bit_cnt_r <= '0;
                            ready_r   <= 1'b1;
                            ocupado_r <= 1'b0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                        end
                    end
                end
                default: begin
                    estado_r  <= ST_IDLE;
                    bit_cnt_r <= '0;
                    saida_r   <= 1'b1;
                    ready_r   <= 1'b1;
                    ocupado_r <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready     = ready_r;
    assign saida_serial = saida_r;
    assign ocupado      = ocupado_r;
    assign pronto       = pronto_r;

endmodule

// File: tb/tb_tx_serial_param.sv
// Bench for tx_serial_param: three instances with different parameter sets,
// a frame-level reference model, per-cycle comparison and literal frame checks.
module tb_tx_serial_param;

    localparam int DBV [3] = '{7, 7, 8};
    localparam int PMV [3] = '{1, 2, 0};
    localparam int SBV [3] = '{1, 1, 2};
    localparam int BDV [3] = '{4, 4, 2};

    localparam int EXP_A  [10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
    localparam int EXP_B  [10] = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 1};
    localparam int EXP_C  [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
    localparam int EXP_55 [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    localparam int EXP_2A [10] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 1};

    logic       clock;
    logic       reset;
    logic [2:0] valid;
    logic [8:0] din [3];
    logic [2:0] line_o;
    logic [2:0] rdy_o;
    logic [2:0] busy_o;
    logic [2:0] done_o;

    int total;
    int bad;

    tx_serial_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .BAUD_DIV(4)) dut_a (
        .clock(clock), .reset(reset), .tx_valid(valid[0]), .tx_ready(rdy_o[0]),
        .dados(din[0][6:0]), .saida_serial(line_o[0]), .ocupado(busy_o[0]), .pronto(done_o[0]));

    tx_serial_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .BAUD_DIV(4)) dut_b (
        .clock(clock), .reset(reset), .tx_valid(valid[1]), .tx_ready(rdy_o[1]),
        .dados(din[1][6:0]), .saida_serial(line_o[1]), .ocupado(busy_o[1]), .pronto(done_o[1]));

    tx_serial_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .BAUD_DIV(2)) dut_c (
        .clock(clock), .reset(reset), .tx_valid(valid[2]), .tx_ready(rdy_o[2]),
        .dados(din[2][7:0]), .saida_serial(line_o[2]), .ocupado(busy_o[2]), .pronto(done_o[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: per instance, whether a frame is in flight, the number of
    // cycles since acceptance, and the full frame as a bit vector.
    logic [2:0]  m_act;
    int          m_off   [3];
    logic [15:0] m_frame [3];

    function automatic int flen(input int i);
        return 1 + DBV[i] + ((PMV[i] != 0) ? 1 : 0) + SBV[i];
    endfunction

    function automatic logic [15:0] build_frame(input int i, input logic [8:0] d);
        logic [15:0] f;
        logic        par;
        f    = '1;
        f[0] = 1'b0;
        par  = 1'b0;
        for (int j = 0; j < DBV[i]; j++) begin
            f[1 + j] = d[j];
            par      = par ^ d[j];
        end
        if (PMV[i] == 2) f[1 + DBV[i]] = ~par;
        else if (PMV[i] == 1) f[1 + DBV[i]] = par;
        return f;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                m_act[i] <= 1'b0;
                m_off[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (m_act[i]) begin
                    if (m_off[i] >= flen(i) * BDV[i]) m_act[i] <= 1'b0;
                    m_off[i] <= m_off[i] + 1;
                end else if (valid[i]) begin
                    m_act[i]   <= 1'b1;
                    m_off[i]   <= 1;
                    m_frame[i] <= build_frame(i, din[i]);
                end
            end
        end
    end

    logic [2:0] rec_line [128];
    logic [2:0] rec_rdy  [128];
    logic [2:0] rec_done [128];
    int         rec_n;
    bit         rec_on;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s t=%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // One clock cycle: compare every instance against the model at the falling edge
    task automatic step();
        int e_line, e_rdy, e_busy, e_done;
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            if (m_act[i]) begin
                e_line = int'(m_frame[i][(m_off[i] - 1) / BDV[i]]);
                e_rdy  = 0;
                e_busy = 1;
                e_done = (m_off[i] == flen(i) * BDV[i]) ? 1 : 0;
            end else begin
                e_line = 1;
                e_rdy  = 1;
                e_busy = 0;
                e_done = 0;
            end
            chk($sformatf("line%0d", i),  int'(line_o[i]), e_line);
            chk($sformatf("ready%0d", i), int'(rdy_o[i]),  e_rdy);
            chk($sformatf("busy%0d", i),  int'(busy_o[i]), e_busy);
            chk($sformatf("pronto%0d", i), int'(done_o[i]), e_done);
        end
        if (rec_on && rec_n < 128) begin
            rec_line[rec_n] = line_o;
            rec_rdy[rec_n]  = rdy_o;
            rec_done[rec_n] = done_o;
            rec_n++;
        end
    endtask

    // Index of the occ-th recorded pronto pulse of instance i, or -1
    function automatic int find_done(input int i, input int occ);
        int seen;
        seen = 0;
        for (int n = 1; n < rec_n; n++) begin
            if (rec_done[n][i]) begin
                seen++;
                if (seen == occ) return n;
            end
        end
        return -1;
    endfunction

    function automatic int count_done(input int i);
        int c;
        c = 0;
        for (int n = 1; n < rec_n; n++) if (rec_done[n][i]) c++;
        return c;
    endfunction

    // Known frames: 7'h41 even/odd parity, 8'hA5 no parity two stop bits
    task automatic run_known();
        valid  = 3'b111;
        din[0] = 9'h041;
        din[1] = 9'h041;
        din[2] = 9'h0A5;
        rec_n  = 1;
        rec_on = 1'b1;
        step();
        valid  = 3'b000;
        din[0] = 9'($urandom);
        din[1] = 9'($urandom);
        din[2] = 9'($urandom);
        repeat (45) step();
        rec_on = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            chk("known_a_line", int'(rec_line[n][0]), EXP_A[(n - 1) / 4]);
            chk("known_b_line", int'(rec_line[n][1]), EXP_B[(n - 1) / 4]);
        end
        for (int n = 1; n <= 22; n++) chk("known_c_line", int'(rec_line[n][2]), EXP_C[(n - 1) / 2]);
        chk("known_a_pronto_at", find_done(0, 1), 40);
        chk("known_a_pronto_cnt", count_done(0), 1);
        chk("known_b_pronto_at", find_done(1, 1), 40);
        chk("known_c_pronto_at", find_done(2, 1), 22);
        chk("known_c_pronto_cnt", count_done(2), 1);
        chk("known_a_ready_40", int'(rec_rdy[40][0]), 0);
        chk("known_a_ready_41", int'(rec_rdy[41][0]), 1);
        chk("known_c_ready_22", int'(rec_rdy[22][2]), 0);
        chk("known_c_ready_23", int'(rec_rdy[23][2]), 1);
    endtask

    // tx_valid held on instance a across two frames, dados changed mid-frame
    task automatic run_back_to_back();
        valid  = 3'b001;
        din[0] = 9'h055;
        rec_n  = 1;
        rec_on = 1'b1;
        for (int s = 1; s <= 90; s++) begin
            step();
            if (s == 20) din[0] = 9'h02A;
            if (s == 42) valid[0] = 1'b0;
            valid[1] = ((s % 7) == 0);
            din[1]   = 9'($urandom);
        end
        valid  = 3'b000;
        rec_on = 1'b0;
        for (int n = 1; n <= 40; n++) chk("b2b_frame1", int'(rec_line[n][0]), EXP_55[(n - 1) / 4]);
        for (int n = 42; n <= 81; n++) chk("b2b_frame2", int'(rec_line[n][0]), EXP_2A[(n - 42) / 4]);
        chk("b2b_pronto1", find_done(0, 1), 40);
        chk("b2b_pronto2", find_done(0, 2), 81);
        chk("b2b_gap_line", int'(rec_line[41][0]), 1);
        chk("b2b_gap_ready", int'(rec_rdy[41][0]), 1);
        chk("b2b_start2", int'(rec_line[42][0]), 0);
        repeat (50) step();
    endtask

    // Asynchronous reset in the middle of the data phase
    task automatic run_reset_abort();
        valid  = 3'b111;
        din[0] = 9'($urandom);
        din[1] = 9'($urandom);
        din[2] = 9'($urandom);
        step();
        valid = 3'b000;
        repeat (9) step();
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("abort_line%0d", i),   int'(line_o[i]), 1);
            chk($sformatf("abort_busy%0d", i),   int'(busy_o[i]), 0);
            chk($sformatf("abort_ready%0d", i),  int'(rdy_o[i]),  1);
            chk($sformatf("abort_pronto%0d", i), int'(done_o[i]), 0);
        end
        repeat (3) step();
        reset = 1'b1;
        repeat (3) step();
        run_known();
    endtask

    initial begin
        int idle_bad [3];
        total  = 0;
        bad    = 0;
        reset  = 1'b0;
        valid  = 3'b000;
        din[0] = '0;
        din[1] = '0;
        din[2] = '0;
        rec_on = 1'b0;
        rec_n  = 0;

        repeat (3) step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_line%0d", i),   int'(line_o[i]), 1);
            chk($sformatf("rst_ready%0d", i),  int'(rdy_o[i]),  1);
            chk($sformatf("rst_busy%0d", i),   int'(busy_o[i]), 0);
            chk($sformatf("rst_pronto%0d", i), int'(done_o[i]), 0);
        end
        reset = 1'b1;
        repeat (3) step();

        run_known();
        run_back_to_back();
        run_reset_abort();

        // Randomised traffic, valid dropped and raised freely
        for (int s = 0; s < 3000; s++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                valid[i] = ($urandom_range(0, 3) != 0);
                din[i]   = 9'($urandom);
            end
        end
        valid = 3'b000;
        repeat (60) step();

        // Long idle stretch
        for (int i = 0; i < 3; i++) idle_bad[i] = 0;
        for (int s = 0; s < 1000; s++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                if (!line_o[i] || done_o[i]) idle_bad[i]++;
            end
        end
        for (int i = 0; i < 3; i++) chk($sformatf("idle_quiet%0d", i), idle_bad[i], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
